// File: rtl/mmu_pkg.sv
// mmu_pkg: shared refill FSM states, trap causes and mmu register bit positions
package mmu_pkg;
    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_FAULT,
        S_WR_ENTRY,
        S_DONE,
        S_TRAP
    } state_t;
    localparam logic [1:0] CAUSE_MISS = 2'd0;
    localparam logic [1:0] CAUSE_PROT = 2'd1;
    localparam logic [1:0] CAUSE_BUS  = 2'd2;
    localparam int VIRT_SEL  = 0;
    localparam int VALID     = 1;
    localparam int WRITEABLE = 2;
    localparam int SUP       = 2;
    localparam int INS       = 3;
endpackage

// File: rtl/mmu_refill_wdog.sv
// mmu_refill_wdog: counts table-read cycles without ack and flags a bus timeout at TIMEOUT
module mmu_refill_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset,
    input  logic i_run,
    input  logic i_ack,
    output logic o_expired
);
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    assign o_expired = r_cnt == CW'(TIMEOUT);
    always_ff @(posedge clk) begin
        if (reset || !i_run)
            r_cnt <= '0;
        else if (!i_ack && !o_expired)
            r_cnt <= r_cnt + 1'b1;
    end
endmodule

// File: rtl/mmu_refill.sv
// mmu_refill: hardware refill sequencer feeding the mmu register port with optional bus watchdog
module mmu_refill
  import mmu_pkg::*;
#(
  parameter int RV = 16,
  parameter int PA = RV,
  parameter int VA = RV,
  parameter int NMMU = 8,
  parameter int TIMEOUT = 255,
  localparam int IW = $clog2(NMMU)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          refill_en,
  input  logic          miss,
  input  logic          prot,
  input  logic [IW-1:0] f_vpn,
  input  logic          f_ins,
  input  logic          f_sup,
  input  logic [RV-1:0] ptbr_u,
  input  logic [RV-1:0] ptbr_s,
  output logic          mem_req,
  output logic [RV-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [RV-1:0] mem_rdata,
  output logic          mmu_reg_write,
  output logic [RV-1:0] mmu_reg_data,
  output logic          stall,
  output logic          retry,
  output logic          trap,
  output logic [1:0]    trap_cause
);
  localparam int UNTOUCHED = VA - IW;
  state_t        state, next;
  logic [IW-1:0] vpn;
  logic          ins, sup, ftype, ok;
  logic [1:0]    cause;
  logic [PA-1:0] addr;
  logic [RV-1:0] entry, sum, fault;
  logic          expired, ack, take;
  assign take     = state == S_IDLE && (miss || prot);
  assign sum      = (f_sup ? ptbr_s : ptbr_u) + RV'({f_ins, f_vpn, 1'b0});
  assign ack      = mem_ack && !expired;
  assign mem_addr = RV'(addr);
`ifdef MMU_REFILL_TIMEOUT_EN
  mmu_refill_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .i_run     (state == S_RD),
    .i_ack     (mem_ack),
    .o_expired (expired)
  );
`else
  assign expired = 1'b0;
`endif
  always_comb begin
    fault = '0;
    fault[UNTOUCHED +: IW] = vpn;
    fault[INS] = ins;
    fault[SUP] = sup;
    fault[VALID] = ftype;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      vpn   <= '0;
      ins   <= 1'b0;
      sup   <= 1'b0;
      ftype <= 1'b0;
      ok    <= 1'b0;
      cause <= CAUSE_MISS;
      addr  <= '0;
      entry <= '0;
    end else begin
      state <= next;
      if (take) begin
        vpn   <= f_vpn;
        ins   <= f_ins;
        sup   <= f_sup;
        ftype <= miss;
        ok    <= 1'b0;
        cause <= miss ? CAUSE_MISS : CAUSE_PROT;
        if (miss && refill_en)
          addr <= sum[PA-1:0];
      end
      if (state == S_RD && ack) begin
        entry <= mem_rdata | (RV'(1) << VIRT_SEL);
        ok    <= mem_rdata[VALID];
      end
      if (state == S_RD && expired)
        cause <= CAUSE_BUS;
    end
  end
  always_comb begin
    next          = state;
    mem_req       = 1'b0;
    mmu_reg_write = 1'b0;
    mmu_reg_data  = '0;
    retry         = 1'b0;
    trap          = 1'b0;
    stall         = state != S_IDLE || miss || prot;
    case (state)
      S_IDLE: next = miss ? (refill_en ? S_RD : S_WR_FAULT) : prot ? S_WR_FAULT : S_IDLE;
      S_RD: begin
        mem_req = !expired;
        if (ack || expired)
          next = S_WR_FAULT;
      end
      S_WR_FAULT: begin
        mmu_reg_write = 1'b1;
        mmu_reg_data  = fault;
        next          = ok ? S_WR_ENTRY : S_TRAP;
      end
      S_WR_ENTRY: begin
        mmu_reg_write = 1'b1;
        mmu_reg_data  = entry;
        next          = S_DONE;
      end
      S_DONE: begin
        retry = 1'b1;
        next  = S_IDLE;
      end
      S_TRAP: begin
        trap = 1'b1;
        next = S_IDLE;
      end
      default: next = S_IDLE;
    endcase
    trap_cause = trap ? cause : 2'd0;
  end
endmodule

// File: doc/mmu_refill.md
Name: mmu_refill

Overview:
Hardware refill sequencer sitting directly upstream of the mmu block's register port. It consumes the mmu's miss/protection fault outputs and fetches the missing translation from an in-memory table (one 16-bit word per entry). It then programs the mmu through its reg_write/reg_data interface and tells the core to retry, or traps to software. The core stays stalled while the sequencer is busy.

Parameters:
RV, 16, machine word width; also mmu register data width
PA, RV, physical address width
VA, RV, virtual address width
NMMU, 8, pages per space; IW=$clog2(NMMU), UNTOUCHED=VA-IW
TIMEOUT, 255, bus watchdog limit in cycles (used only with MMU_REFILL_TIMEOUT_EN)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
refill_en  in  1  1 = hardware refill; 0 = every miss traps
miss  in  1  mmu miss fault, current access
prot  in  1  mmu protection fault, current access
f_vpn  in  IW  faulting virtual page (pcv or addrv upper bits)
f_ins  in  1  faulting access is an instruction fetch
f_sup  in  1  effective supervisor space of the access
ptbr_u  in  RV  user table base, byte address
ptbr_s  in  RV  supervisor table base, byte address
mem_req  out  1  table read request, held until mem_ack
mem_addr  out  RV  table word byte address
mem_ack  in  1  read complete; mem_rdata valid this cycle
mem_rdata  in  RV  table entry (mmu virt-write format)
mmu_reg_write  out  1  mmu register write strobe
mmu_reg_data  out  RV  mmu register write data
stall  out  1  hold core pipeline
retry  out  1  one-cycle pulse: re-issue the faulting access
trap  out  1  one-cycle pulse: take MMU exception
trap_cause  out  2  0 miss-invalid, 1 prot, 2 bus-timeout; valid with trap

Behaviour:
- Reset: state IDLE. All outputs are 0.
- States: IDLE, RD, WR_FAULT, WR_ENTRY, DONE, TRAP.
- IDLE, miss=1, refill_en=1:
  - Latch vpn/ins/sup.
  - mem_addr = (f_sup ? ptbr_s : ptbr_u) + {f_ins, f_vpn, 1'b0}, truncated to RV bits (wraps).
  - Go to RD.
- IDLE, miss=1, refill_en=0: latch, cause=0, go to WR_FAULT.
- IDLE, prot=1 and miss=0: latch, cause=1, go to WR_FAULT.
- Simultaneous miss and prot: miss has priority.
- Fault inputs are ignored while not IDLE.
- RD:
  - mem_req=1 and mem_addr held stable until mem_ack.
  - On ack, latch mem_rdata.
  - Entry bit1=1: go to WR_FAULT, then WR_ENTRY.
  - Entry bit1=0: cause=0, go to WR_FAULT, then TRAP.
- WR_FAULT (one cycle):
  - mmu_reg_write=1.
  - data = {vpn, zeros, ins, sup, type, 1'b0}; type=1 for miss, 0 for prot.
  - This selects the mmu target entry and leaves the fault info readable by software.
- WR_ENTRY (one cycle): mmu_reg_write=1, data = latched entry with bit0 forced to 1.
- DONE: retry=1 for one cycle, then IDLE.
- TRAP: trap=1 for one cycle with trap_cause, then IDLE.
- stall=1 when state!=IDLE, or when IDLE with miss|prot asserted (combinational).
- Latency, mem_ack in the first RD cycle: fault to retry = 4 cycles.
- Reset mid-operation: immediate IDLE; mem_req drops; no further mmu writes.

Optional Feature:
MMU_REFILL_TIMEOUT_EN
- Defined:
  - Counter cleared on entry to RD, increments each RD cycle without mem_ack.
  - When the count reaches TIMEOUT: drop mem_req, cause=2, go to WR_FAULT then TRAP (fault type=1).
- Undefined: no counter; RD waits indefinitely.

Decomposition:
- Shared package mmu_pkg holds:
  - state enum;
  - trap_cause constants (CAUSE_MISS=0, CAUSE_PROT=1, CAUSE_BUS=2);
  - mmu register bit positions (VIRT_SEL=0, VALID=1, WRITEABLE=2, SUP=2, INS=3).
- Sub-module mmu_refill_wdog (timeout counter) is instantiated only under the macro.

Test Plan:
- Data refill, user, vpn=3, ptbr_u=0x4000, ins=0:
  - mem_addr=0x4006; ack with rdata=0xA006.
  - Writes 0x6002 then 0xA007; retry pulse; stall deasserts the next cycle.
- Instruction refill, supervisor, vpn=3, ptbr_s=0x8000:
  - mem_addr=0x8016; rdata=0x2002.
  - Writes 0x600E then 0x2003; retry.
- Invalid entry, user data vpn=3: rdata=0x0000 -> write 0x6002, trap with cause=0, no second write.
- Protection fault, supervisor data vpn=5: no mem_req; write 0xA004; trap with cause=1.
- miss and prot together: miss path taken. refill_en=0 with a miss: trap cause=0, no mem_req.
- Reset asserted during RD with mem_req=1: the next cycle mem_req=0, stall=0, no mmu_reg_write. With the macro defined and TIMEOUT=4, no ack: trap cause=2.
